// File: rtl/arbiter_grant_mux.sv
// arbiter_grant_mux: presents client valids to the round-robin arbiter and muxes the granted beat into one registered stream; the first beat of a multi-beat packet locks the client until its last beat.
// Latency: arb_req -> arb_gnt 1 cycle (arbiter), arb_gnt -> m_valid 1 cycle; sustains 1 beat/cycle when m_ready stays high.
// Backpressure: a beat is accepted only if the output register is empty or draining; grants that cannot be honoured are discarded and re-requested. Optional ARB_GRANT_MUX_STATS_EN adds per-client accepted-beat counters.
module arbiter_grant_mux #(
  parameter int CLIENTS    = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CLIENTS-1:0]            s_valid,
  input  logic [CLIENTS-1:0]            s_last,
  input  logic [CLIENTS*DATA_WIDTH-1:0] s_data,
  output logic [CLIENTS-1:0]            s_ready,
  output logic [CLIENTS-1:0]            arb_req,
  input  logic [CLIENTS-1:0]            arb_gnt,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_last,
  output logic [ID_WIDTH-1:0]           m_id,
`ifdef ARB_GRANT_MUX_STATS_EN
  input  logic [ID_WIDTH-1:0]           stat_sel,
  input  logic                          stat_clr,
  output logic [15:0]                   stat_cnt,
`endif
  output logic                          gnt_err
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   lock_q, lock_d;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_last_q;
  logic [ID_WIDTH-1:0]   m_id_q;
  logic                  gnt_err_q;

  logic                  out_free;
  logic                  gnt_ok;
  logic                  gnt_multi;
  logic [ID_WIDTH-1:0]   gidx;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CLIENTS-1:0]    lock_onehot;
  logic                  accept;

  assign out_free    = ~m_valid_q | m_ready;
  assign gnt_ok      = (arb_gnt != '0) && ((arb_gnt & (arb_gnt - CLIENTS'(1))) == '0);
  assign gnt_multi   = (arb_gnt != '0) && !gnt_ok;
  assign lock_onehot = CLIENTS'(1) << lock_q;

  // Decode the grant index and pick that client's beat (only meaningful when gnt_ok).
  always_comb begin
    gidx      = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (arb_gnt[i]) gidx = gidx | ID_WIDTH'(i);
    end
    for (int i = 0; i < CLIENTS; i++) begin
      if (ID_WIDTH'(i) == gidx) begin
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
        sel_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Request masking and accept decision; while locked only the owning client may win.
  always_comb begin
    arb_req = s_valid;
    accept  = 1'b0;
    if (state_q == ST_LOCKED) begin
      arb_req = s_valid & lock_onehot;
      accept  = gnt_ok && (gidx == lock_q) && sel_valid && out_free && !rst;
    end else begin
      accept  = gnt_ok && sel_valid && out_free && !rst;
    end
    s_ready = accept ? arb_gnt : '0;
  end

  // Packet lock FSM next state: non-last beat in IDLE locks, last beat in LOCKED releases.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    if (accept) begin
      if (state_q == ST_IDLE) begin
        if (!sel_last) begin
          state_d = ST_LOCKED;
          lock_d  = gidx;
        end
      end else if (sel_last) begin
        state_d = ST_IDLE;
      end
    end
  end

  // FSM and lock index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // Output register: refill on accept, otherwise drain when downstream takes the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_data_q  <= sel_data;
      m_last_q  <= sel_last;
      m_id_q    <= gidx;
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  // Sticky multi-hot grant flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) gnt_err_q <= 1'b0;
    else     gnt_err_q <= gnt_err_q | gnt_multi;
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_id    = m_id_q;
  assign gnt_err = gnt_err_q;

`ifdef ARB_GRANT_MUX_STATS_EN
  logic [15:0] cnt_q [CLIENTS];

  // Per-client saturating accepted-beat counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < CLIENTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CLIENTS; i++) begin
        if (accept && (gidx == ID_WIDTH'(i)) && (cnt_q[i] != 16'hFFFF)) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Combinational counter read port.
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (ID_WIDTH'(i) == stat_sel) stat_cnt = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_arbiter_grant_mux.sv
// tb_arbiter_grant_mux: drives arbiter_grant_mux with per-client packet sources and a behavioural round-robin arbiter.
// Expected beats are queued per client when stimulus is created and popped when the DUT emits them.
// Directed checks cover reset, timing, alternation, packet lock, stalls, multi-hot grants and mid-packet reset.
module tb_arbiter_grant_mux;

  localparam int N  = 16;
  localparam int DW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  s_valid, s_last, s_ready, arb_req, arb_gnt;
  logic [N*DW-1:0] s_data;
  logic          m_valid, m_ready, m_last, gnt_err;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_id;
`ifdef ARB_GRANT_MUX_STATS_EN
  logic [IW-1:0] stat_sel;
  logic          stat_clr;
  logic [15:0]   stat_cnt;
`endif

  arbiter_grant_mux #(.CLIENTS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_ready(s_ready),
    .arb_req(arb_req), .arb_gnt(arb_gnt),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_id(m_id),
`ifdef ARB_GRANT_MUX_STATS_EN
    .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt),
`endif
    .gnt_err(gnt_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [32:0] src_q [N][$];
  logic [32:0] sb_q  [N][$];
  int          out_log[$];
  int          out_cyc[$];
  int          cyc = 0;
  int          req4_seen = 0;

  logic [N-1:0]  s_ready_s, arb_req_s, hs_s;
  logic          m_valid_s, m_last_s, gnt_err_s, mhs_s;
  logic [DW-1:0] m_data_s;
  logic [IW-1:0] m_id_s;

  int            rr_ptr = 0;
  logic          force_en;
  logic [N-1:0]  force_gnt;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        s_valid[i] = 1'b1;
        s_last[i]  = src_q[i][0][32];
        s_data[i*DW +: DW] = src_q[i][0][31:0];
      end else begin
        s_valid[i] = 1'b0;
        s_last[i]  = 1'b0;
        s_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic push(input int c, input logic [31:0] d, input logic l);
    src_q[c].push_back({l, d});
    sb_q[c].push_back({l, d});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) begin
      if (sb_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock: sample at the falling edge, then update sources and arbiter just after the rising edge.
  task automatic cycle();
    logic [32:0] exp_beat;
    @(negedge clk);
    cyc++;
    s_ready_s = s_ready;
    arb_req_s = arb_req;
    hs_s      = s_valid & s_ready;
    m_valid_s = m_valid;
    m_data_s  = m_data;
    m_last_s  = m_last;
    m_id_s    = m_id;
    gnt_err_s = gnt_err;
    mhs_s     = m_valid & m_ready;
    if (arb_req == 16'h0004) req4_seen++;
    check("s_ready_onehot0", $countones(s_ready) <= 1, 1'b1);
    if (mhs_s) begin
      out_log.push_back(int'(m_id));
      out_cyc.push_back(cyc);
      check("sb_beat_pending", sb_q[m_id].size() != 0, 1'b1);
      if (sb_q[m_id].size() != 0) begin
        exp_beat = sb_q[m_id].pop_front();
        check("sb_beat", {m_last, m_data}, exp_beat);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    if (rst) begin
      arb_gnt = '0;
    end else if (force_en) begin
      arb_gnt = force_gnt;
    end else begin
      arb_gnt = '0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (rr_ptr + k) % N;
        if (arb_req_s[idx] && arb_gnt == '0) begin
          arb_gnt[idx] = 1'b1;
          rr_ptr = (idx + 1) % N;
        end
      end
    end
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      cycle();
      n++;
    end
    check(tag, all_empty(), 1'b1);
  endtask

  initial begin
    logic [DW-1:0] held_data;
    bit held;
    int bad;
    int exp_ids[6];

    rst = 1'b1; m_ready = 1'b1; force_en = 1'b0; force_gnt = '0; arb_gnt = '0;
    s_valid = '0; s_last = '0; s_data = '0;
`ifdef ARB_GRANT_MUX_STATS_EN
    stat_sel = '0; stat_clr = 1'b0;
`endif
    drive();
    repeat (3) cycle();
    check("rst_m_valid", m_valid_s, 1'b0);
    check("rst_m_data", m_data_s, 32'h0);
    check("rst_m_last", m_last_s, 1'b0);
    check("rst_m_id", m_id_s, 4'h0);
    check("rst_gnt_err", gnt_err_s, 1'b0);
    check("rst_s_ready", s_ready_s, 16'h0);
    rst = 1'b0;

    // Single one-beat packet from client 3, checking each stage's timing.
    push(3, 32'hA5A5A5A5, 1'b1);
    drive();
    cycle();
    check("t1_arb_req", arb_req_s, 16'h0008);
    check("t1_no_ready_before_gnt", s_ready_s, 16'h0000);
    cycle();
    check("t1_s_ready", s_ready_s, 16'h0008);
    cycle();
    check("t1_m_valid", m_valid_s, 1'b1);
    check("t1_m_data", m_data_s, 32'hA5A5A5A5);
    check("t1_m_id", m_id_s, 4'd3);
    check("t1_m_last", m_last_s, 1'b1);
    check("t1_s_ready_once", s_ready_s, 16'h0000);
    cycle();
    check("t1_m_valid_drop", m_valid_s, 1'b0);
    drain("t1_drain", 10);

    // Clients 0 and 5 streaming one-beat packets: alternate at full rate.
    out_log.delete(); out_cyc.delete();
    for (int k = 0; k < 6; k++) begin
      push(0, {8'h00, 8'hBE, 16'(k)}, 1'b1);
      push(5, {8'h05, 8'hBE, 16'(k)}, 1'b1);
    end
    drive();
    drain("t2_drain", 100);
    check("t2_beats", out_log.size(), 12);
    bad = 0;
    for (int j = 1; j < out_log.size(); j++) if (out_log[j] == out_log[j-1]) bad++;
    check("t2_alternate", bad, 0);
    if (out_cyc.size() == 12) check("t2_rate", out_cyc[11] - out_cyc[0], 11);

    // Client 2 four-beat packet with client 7 competing.
    out_log.delete(); req4_seen = 0;
    for (int k = 0; k < 4; k++) push(2, {8'h02, 8'hBE, 16'(k)}, k == 3);
    drive();
    cycle();
    push(7, {8'h07, 8'hBE, 16'd0}, 1'b1);
    push(7, {8'h07, 8'hBE, 16'd1}, 1'b1);
    drive();
    drain("t3_drain", 100);
    check("t3_locked_req", req4_seen > 0, 1'b1);
    check("t3_beats", out_log.size(), 6);
    exp_ids = '{2, 2, 2, 2, 7, 7};
    for (int j = 0; j < 6; j++) begin
      if (j < out_log.size()) check($sformatf("t3_order_%0d", j), out_log[j], exp_ids[j]);
    end

    // Downstream stall with three requesters.
    m_ready = 1'b0; held = 1'b0; held_data = '0;
    for (int k = 0; k < 2; k++) begin
      push(1, {8'h01, 8'hBE, 16'(k)}, 1'b1);
      push(6, {8'h06, 8'hBE, 16'(k)}, 1'b1);
      push(9, {8'h09, 8'hBE, 16'(k)}, 1'b1);
    end
    drive();
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (held) begin
        check("t4_hold_valid", m_valid_s, 1'b1);
        check("t4_hold_data", m_data_s, held_data);
        check("t4_hold_no_ready", s_ready_s, 16'h0);
      end else if (m_valid_s) begin
        held = 1'b1;
        held_data = m_data_s;
      end
    end
    check("t4_first_accept", held, 1'b1);
    m_ready = 1'b1;
    drain("t4_drain", 100);

    // Multi-hot grant is ignored and latches gnt_err.
    force_en = 1'b1; force_gnt = 16'h0011; arb_gnt = 16'h0011;
    push(0, {8'h00, 8'hCD, 16'd0}, 1'b1);
    push(4, {8'h04, 8'hCD, 16'd0}, 1'b1);
    drive();
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t5_multihot_no_ready", s_ready_s, 16'h0);
    end
    check("t5_gnt_err_set", gnt_err_s, 1'b1);
    force_en = 1'b0;
    drain("t5_drain", 50);
    check("t5_gnt_err_sticky", gnt_err_s, 1'b1);

    // Reset in the middle of a packet.
    for (int k = 0; k < 4; k++) push(2, {8'h02, 8'hEE, 16'(k)}, k == 3);
    drive();
    held = 1'b0;
    for (int k = 0; k < 20 && !held; k++) begin
      cycle();
      if (m_valid_s && m_id_s == 4'd2) held = 1'b1;
    end
    check("t6_pkt_started", held, 1'b1);
    m_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      sb_q[i].delete();
    end
    drive();
    cycle();
    check("t6_rst_m_valid", m_valid_s, 1'b0);
    check("t6_rst_gnt_err", gnt_err_s, 1'b0);
    out_log.delete();
    push(9, {8'h09, 8'hEE, 16'd0}, 1'b1);
    drive();
    drain("t6_idle_after_rst", 20);
    check("t6_served_id", out_log.size() > 0 ? out_log[out_log.size()-1] : -1, 9);

`ifdef ARB_GRANT_MUX_STATS_EN
    for (int k = 0; k < 10; k++) push(4, {8'h04, 8'h57, 16'(k)}, 1'b1);
    drive();
    drain("st_drain", 100);
    stat_sel = 4'd4;
    #1;
    check("stat_cnt_10", stat_cnt, 16'd10);
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    #1;
    check("stat_cnt_clr", stat_cnt, 16'd0);
`endif

    check("sb_final_empty", all_empty(), 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arbiter_grant_mux.md
Name: arbiter_grant_mux

Overview:
- Companion stage wrapped around the round-robin arbiter.
- Presents per-client valid/data streams to the arbiter as a request vector.
- Consumes the arbiter's registered one-hot grant and muxes the granted client's beat into a single registered output stream, with valid/ready handshaking on both sides.
- Supports multi-beat packets: the first beat locks the selected client until its last beat.

Parameters:
- CLIENTS, 16, number of requesting clients; must match the arbiter's CLIENTS.
- DATA_WIDTH, 32, payload width per client.
- ID_WIDTH, $clog2(CLIENTS) (minimum 1), width of the output client index.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- s_valid  input  CLIENTS  per-client beat valid
- s_last  input  CLIENTS  per-client last beat of packet
- s_data  input  CLIENTS*DATA_WIDTH  packed payloads; client i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_ready  output  CLIENTS  per-client accept, combinational
- arb_req  output  CLIENTS  request vector to the arbiter, combinational
- arb_gnt  input  CLIENTS  registered one-hot grant from the arbiter
- m_valid  output  1  output beat valid
- m_ready  input  1  downstream accept
- m_data  output  DATA_WIDTH  output payload
- m_last  output  1  output last flag
- m_id  output  ID_WIDTH  index of the client that supplied the beat
- gnt_err  output  1  sticky flag: arb_gnt had more than one bit set

Behaviour:
- Reset (synchronous, rst=1), all registered outputs clear:
  - m_valid=0, m_data=0, m_last=0, m_id=0, gnt_err=0.
  - FSM to IDLE, lock index cleared to 0.
- out_free = ~m_valid | m_ready.
- gidx = index of the single set bit of arb_gnt.
- gnt_ok = arb_gnt is exactly one-hot.
- FSM state IDLE:
  - arb_req = s_valid.
  - accept = gnt_ok & s_valid[gidx] & out_free.
  - On accept:
    - s_ready[gidx]=1.
    - Next cycle: m_data=s_data[gidx], m_last=s_last[gidx], m_id=gidx, m_valid=1.
    - If s_last[gidx]=0, latch lock=gidx and go to LOCKED.
- FSM state LOCKED:
  - arb_req = one-hot(lock) & s_valid. A lone requester is always granted by the arbiter.
  - accept only when gnt_ok, gidx==lock, s_valid[lock] and out_free.
  - A grant to any other index is ignored; s_ready stays 0.
  - On accept with s_last[lock]=1, return to IDLE.
- Output register:
  - m_valid cleared when m_ready=1 and there is no accept in the same cycle.
  - Accept with m_ready=1 refills in the same cycle, sustaining 1 beat/cycle.
- At most one s_ready bit is high in any cycle; s_ready is 0 whenever there is no accept.
- Lost grants: a grant that fails the accept condition (output stalled, client valid dropped, wrong client while locked) is discarded. The request persists and the arbiter re-grants later. No beat is dropped or duplicated.
- gnt_err sets when arb_gnt has 2 or more bits set. A multi-hot grant is treated as no grant. gnt_err clears only on reset.
- An all-zero arb_gnt is a no-op.
- Latency: arb_req to arb_gnt is 1 cycle (arbiter); arb_gnt to m_valid is 1 cycle.
- Reset mid-packet returns the FSM to IDLE and drops the output beat. Clients must restart their packets.

Optional Feature:
- Macro: ARB_GRANT_MUX_STATS_EN.
- When defined, adds:
  - input stat_sel (ID_WIDTH).
  - input stat_clr (1).
  - output stat_cnt (16).
- Per-client 16-bit saturating counters of accepted beats (saturate at 0xFFFF).
- Counters clear on rst or stat_clr; stat_clr wins over a same-cycle increment.
- stat_cnt = counter[stat_sel], combinational read.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single client 3, one beat: s_valid=0x0008, s_last[3]=1, data 0xA5A5A5A5, m_ready=1 -> arb_req=0x0008; grant next cycle; s_ready[3] pulses once; m_valid=1 one cycle later with m_data=0xA5A5A5A5, m_id=3, m_last=1.
- Clients 0 and 5, continuous one-beat requests, m_ready=1 -> m_id alternates between 0 and 5; one beat per cycle in steady state; no s_ready overlap.
- Client 2 sends a 4-beat packet while client 7 is requesting -> in LOCKED, arb_req=0x0004; m_id=2 for 4 consecutive beats with m_last on beat 4; client 7 is served afterwards.
- m_ready=0 for 5 cycles with 3 clients requesting -> m_valid held with m_data stable; all s_ready=0 after the first accept; no loss or duplication after m_ready returns to 1.
- Force arb_gnt=0x0011 -> no accept, gnt_err=1 and stays 1 until rst; rst mid-packet -> FSM IDLE, m_valid=0.
- With ARB_GRANT_MUX_STATS_EN: 10 beats from client 4 -> stat_sel=4 reads stat_cnt=10; stat_clr -> 0.
